// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The master side is the sequencer: it reads instruction fields and the
// zero flag, and drives every enable, select and status signal.
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       OPCode;
   logic [5:0]       FUNCode;
   logic             Zero;
   logic             PCWr;
   logic             IRWr;
   logic             RWE;
   logic             DWE;
   logic [1:0]       NPCOp;
   logic [1:0]       WAOp;
   logic [1:0]       WDOp;
   logic [1:0]       EXTOp;
   logic             ALUBOp;
   logic [1:0]       ALUOp;
   logic [2:0]       State;
   logic             Retire;
   logic             Illegal;
   logic [CNT_W-1:0] RetCnt;

   modport master (
      input  OPCode, FUNCode, Zero,
      output PCWr, IRWr, RWE, DWE, NPCOp, WAOp, WDOp, EXTOp, ALUBOp, ALUOp,
             State, Retire, Illegal, RetCnt
   );

   modport slave (
      output OPCode, FUNCode, Zero,
      input  PCWr, IRWr, RWE, DWE, NPCOp, WAOp, WDOp, EXTOp, ALUBOp, ALUOp,
             State, Retire, Illegal, RetCnt
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller for the MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// latches an instruction class at the end of DECODE so later states never
// depend on the live IR fields, counts retired instructions and flags
// unsupported encodings. Enables are gated low for as long as reset is high.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic      clk,
   input  logic      reset,
   mc_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      C_NOP  = 4'd0,
      C_ADDU = 4'd1,
      C_SUBU = 4'd2,
      C_ORI  = 4'd3,
      C_LUI  = 4'd4,
      C_LW   = 4'd5,
      C_SW   = 4'd6,
      C_BEQ  = 4'd7,
      C_J    = 4'd8,
      C_JAL  = 4'd9,
      C_JR   = 4'd10,
      C_ILL  = 4'd11
   } cls_t;

   state_t           state_r;
   cls_t             cls_r;
   logic [CNT_W-1:0] cnt_r;

   cls_t             dec_s;
   logic             pcwr_s;
   logic             irwr_s;
   logic             rwe_s;
   logic             dwe_s;
   logic [1:0]       npcop_s;
   logic [1:0]       waop_s;
   logic [1:0]       wdop_s;
   logic [1:0]       extop_s;
   logic             alubop_s;
   logic [1:0]       aluop_s;
   logic             retire_s;
   logic             illegal_s;

   // Classify the live IR fields; only meaningful while in DECODE.
   always_comb begin
      dec_s = C_ILL;
      case (bus.OPCode)
         6'b000000: begin
            case (bus.FUNCode)
               6'b100001: dec_s = C_ADDU;
               6'b100011: dec_s = C_SUBU;
               6'b001000: dec_s = C_JR;
               6'b000000: dec_s = C_NOP;
               default:   dec_s = C_ILL;
            endcase
         end
         6'b001101: dec_s = C_ORI;
         6'b001111: dec_s = C_LUI;
         6'b100011: dec_s = C_LW;
         6'b101011: dec_s = C_SW;
         6'b000100: dec_s = C_BEQ;
         6'b000010: dec_s = C_J;
         6'b000011: dec_s = C_JAL;
         default:   dec_s = C_ILL;
      endcase
   end

   // Sequencer state, latched instruction class and retired-instruction counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= FETCH;
         cls_r   <= C_NOP;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         if (retire_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end
         case (state_r)
            FETCH: state_r <= DECODE;
            DECODE: begin
               cls_r <= dec_s;
               case (dec_s)
                  C_ADDU, C_SUBU, C_ORI, C_LUI,
                  C_LW, C_SW, C_BEQ:   state_r <= EXECUTE;
                  C_JAL:               state_r <= WRITEBACK;
                  default:             state_r <= FETCH;
               endcase
            end
            EXECUTE: begin
               case (cls_r)
                  C_LW, C_SW:                    state_r <= MEMORY;
                  C_ADDU, C_SUBU, C_ORI, C_LUI:  state_r <= WRITEBACK;
                  default:                       state_r <= FETCH;
               endcase
            end
            MEMORY: begin
               case (cls_r)
                  C_LW:    state_r <= WRITEBACK;
                  default: state_r <= FETCH;
               endcase
            end
            WRITEBACK: state_r <= FETCH;
            default:   state_r <= FETCH;
         endcase
      end
   end

   // Per-state enables and selects; everything idles at 0 while reset is high.
   always_comb begin
      pcwr_s    = 1'b0;
      irwr_s    = 1'b0;
      rwe_s     = 1'b0;
      dwe_s     = 1'b0;
      npcop_s   = 2'b00;
      waop_s    = 2'b00;
      wdop_s    = 2'b00;
      extop_s   = 2'b00;
      alubop_s  = 1'b0;
      aluop_s   = 2'b00;
      retire_s  = 1'b0;
      illegal_s = 1'b0;
      if (reset) begin
         pcwr_s = 1'b0;
         irwr_s = 1'b0;
      end else begin
         case (state_r)
            FETCH: begin
               irwr_s = 1'b1;
               pcwr_s = 1'b1;
            end
            DECODE: begin
               case (dec_s)
                  C_J: begin
                     pcwr_s   = 1'b1;
                     npcop_s  = 2'b10;
                     retire_s = 1'b1;
                  end
                  C_JAL: begin
                     pcwr_s  = 1'b1;
                     npcop_s = 2'b10;
                  end
                  C_JR: begin
                     pcwr_s   = 1'b1;
                     npcop_s  = 2'b11;
                     retire_s = 1'b1;
                  end
                  C_NOP: retire_s = 1'b1;
                  C_ILL: begin
                     illegal_s = 1'b1;
                     retire_s  = 1'b1;
                  end
                  default: retire_s = 1'b0;
               endcase
            end
            EXECUTE: begin
               case (cls_r)
                  C_ADDU: aluop_s = 2'b00;
                  C_SUBU: aluop_s = 2'b01;
                  C_ORI: begin
                     aluop_s  = 2'b10;
                     alubop_s = 1'b1;
                  end
                  C_LUI: begin
                     aluop_s  = 2'b11;
                     alubop_s = 1'b1;
                  end
                  C_LW, C_SW: begin
                     alubop_s = 1'b1;
                     extop_s  = 2'b01;
                  end
                  C_BEQ: begin
                     aluop_s  = 2'b01;
                     extop_s  = 2'b01;
                     npcop_s  = 2'b01;
                     pcwr_s   = bus.Zero;
                     retire_s = 1'b1;
                  end
                  default: aluop_s = 2'b00;
               endcase
            end
            MEMORY: begin
               if (cls_r == C_SW) begin
                  dwe_s    = 1'b1;
                  retire_s = 1'b1;
               end else begin
                  dwe_s = 1'b0;
               end
            end
            WRITEBACK: begin
               rwe_s    = 1'b1;
               retire_s = 1'b1;
               case (cls_r)
                  C_ADDU, C_SUBU: waop_s = 2'b01;
                  C_LW:           wdop_s = 2'b01;
                  C_JAL: begin
                     waop_s = 2'b10;
                     wdop_s = 2'b10;
                  end
                  default: waop_s = 2'b00;
               endcase
            end
            default: retire_s = 1'b0;
         endcase
      end
   end

   assign bus.PCWr    = pcwr_s;
   assign bus.IRWr    = irwr_s;
   assign bus.RWE     = rwe_s;
   assign bus.DWE     = dwe_s;
   assign bus.NPCOp   = npcop_s;
   assign bus.WAOp    = waop_s;
   assign bus.WDOp    = wdop_s;
   assign bus.EXTOp   = extop_s;
   assign bus.ALUBOp  = alubop_s;
   assign bus.ALUOp   = aluop_s;
   assign bus.State   = state_r;
   assign bus.Retire  = retire_s;
   assign bus.Illegal = illegal_s;
   assign bus.RetCnt  = cnt_r;

endmodule
